// File: rtl/add_sub_serial_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// add_sub_serial_pkg: state encoding and helpers for add_sub_serial_p
// Rev 1.0
// ------------------------------------------------------------------
package add_sub_serial_pkg;

  localparam int MAX_DECOY = 8;

  // Dense 4-bit codes; decoy codes are scattered between the real ones.
  typedef enum logic [3:0] {
    ST_DECOY_1 = 4'h0,
    ST_RUN     = 4'h3,
    ST_DECOY_4 = 4'h5,
    ST_IDLE    = 4'h6,
    ST_DECOY_6 = 4'h7,
    ST_DECOY_2 = 4'h9,
    ST_DONE    = 4'hA,
    ST_DECOY_7 = 4'hB,
    ST_DECOY_0 = 4'hC,
    ST_DECOY_5 = 4'hE,
    ST_DECOY_3 = 4'hF
  } state_t;

  function automatic int cnt_width(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

  function automatic state_t decoy_state(input int idx);
    case (idx)
      0:       return ST_DECOY_0;
      1:       return ST_DECOY_1;
      2:       return ST_DECOY_2;
      3:       return ST_DECOY_3;
      4:       return ST_DECOY_4;
      5:       return ST_DECOY_5;
      6:       return ST_DECOY_6;
      7:       return ST_DECOY_7;
      default: return ST_DECOY_0;
    endcase
  endfunction

  function automatic int decoy_index(input state_t s);
    case (s)
      ST_DECOY_1: return 1;
      ST_DECOY_2: return 2;
      ST_DECOY_3: return 3;
      ST_DECOY_4: return 4;
      ST_DECOY_5: return 5;
      ST_DECOY_6: return 6;
      ST_DECOY_7: return 7;
      default:    return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub_digit.sv
`default_nettype none
// ------------------------------------------------------------------
// add_sub_digit: combinational DIGIT-bit ripple adder with MSB carry-in
// Rev 1.0
// ------------------------------------------------------------------
module add_sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    c        = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = da[i] ^ db[i] ^ c;
      c    = (da[i] & db[i]) | (c & (da[i] ^ db[i]));
    end
    cout = c;
  end

endmodule
`default_nettype wire

// File: rtl/add_sub_serial_p.sv
`default_nettype none
// ------------------------------------------------------------------
// add_sub_serial_p: digit-serial add/subtract, masked operands, key lock
// Rev 1.0
// ------------------------------------------------------------------
module add_sub_serial_p
  import add_sub_serial_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               DIGIT   = 1,
  parameter logic [WIDTH-1:0] A_MASK  = '0,
  parameter logic [WIDTH-1:0] B_MASK  = '0,
  parameter int               KEY_W   = 8,
  parameter logic [KEY_W-1:0] KEY     = KEY_W'(8'hA5),
  parameter int               N_DECOY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [KEY_W-1:0] key,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic             carry;
  logic [CW-1:0]    count;

  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic [DIGIT-1:0] s;
  logic             c;
  logic             c_msb;

  // Masks are stripped one digit at a time as the operand leaves the register.
  assign da = a_reg[DIGIT-1:0] ^ A_MASK[count*DIGIT +: DIGIT];
  assign db = (b_reg[DIGIT-1:0] ^ B_MASK[count*DIGIT +: DIGIT]) ^ {DIGIT{sub_reg}};

  add_sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .da       (da),
    .db       (db),
    .cin      (carry),
    .s        (s),
    .cout     (c),
    .c_msb_in (c_msb)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      carry   <= 1'b0;
      count   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (key == KEY) begin
              a_reg   <= a ^ A_MASK;
              b_reg   <= b ^ B_MASK;
              sub_reg <= sub;
              carry   <= sub;
              count   <= '0;
              result  <= '0;
              state   <= ST_RUN;
            end else begin
              state <= ST_DECOY_0;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            result <= WIDTH'({s, result} >> DIGIT);
            a_reg  <= a_reg >> DIGIT;
            b_reg  <= b_reg >> DIGIT;
            carry  <= c;
            count  <= count + 1'b1;
            if (count == CW'(NDIG - 1)) begin
              cout  <= c;
              ovf   <= c ^ c_msb;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (flush || out_ready) state <= ST_IDLE;
        end
        ST_DECOY_0, ST_DECOY_1, ST_DECOY_2, ST_DECOY_3,
        ST_DECOY_4, ST_DECOY_5, ST_DECOY_6, ST_DECOY_7: begin
          state <= decoy_state((decoy_index(state) + 1) % N_DECOY);
        end
        default: state <= ST_DECOY_0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_sub_serial_p.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_add_sub_serial_p: directed + random checks of add_sub_serial_p
// Rev 1.0
// ------------------------------------------------------------------
module tb_add_sub_serial_p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       sub = 1'b0;
  logic [7:0] key = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       cout;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  add_sub_serial_p #(
    .WIDTH   (8),
    .DIGIT   (2),
    .A_MASK  (8'h3C),
    .B_MASK  (8'hC5),
    .KEY_W   (8),
    .KEY     (8'hA5),
    .N_DECOY (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .key       (key),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {cout, ovf, result}.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int sx, sy, r;
    logic [7:0] res;
    logic co, ov;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      res = 8'(x - y);
      co  = (x >= y);
      r   = sx - sy;
    end else begin
      res = 8'(x + y);
      co  = (int'(x) + int'(y)) > 255;
      r   = sx + sy;
    end
    ov = (r > 127) || (r < -128);
    return {co, ov, res};
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input int hold);
    logic [9:0] exp;
    exp = model(ta, tb, ts);
    wait_idle();
    a = ta; b = tb; sub = ts; key = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) begin
      check("latency_low", out_valid, 0);
      tick();
    end
    check("latency_high", out_valid, 1);
    check("result", result, exp[7:0]);
    check("cout", cout, exp[9]);
    check("ovf", ovf, exp[8]);
    out_ready = 1'b0;
    repeat (hold) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_result", {cout, ovf, result}, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("accept_idle", {in_ready, out_valid}, 2'b10);
    check("accept_keep", {cout, ovf, result}, exp);
  endtask

  initial begin
    logic [9:0] last;
    // Reset state
    repeat (2) tick();
    check("rst_ready", in_ready, 1);
    check("rst_outs", {out_valid, cout, ovf, result}, 0);
    rst = 1'b0;
    tick();

    run_op(8'h7F, 8'h01, 1'b0, 0);   // add overflow
    run_op(8'h05, 8'h07, 1'b1, 0);   // borrow
    run_op(8'h80, 8'h01, 1'b1, 0);   // sub overflow
    run_op(8'hFF, 8'h01, 1'b0, 10);  // carry-out under backpressure

    // Flush on the second RUN cycle
    wait_idle();
    a = 8'h55; b = 8'h11; sub = 1'b0; key = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {in_ready, out_valid}, 2'b10);
    repeat (6) begin
      tick();
      check("flush_no_valid", out_valid, 0);
    end
    run_op(8'h10, 8'h20, 1'b0, 0);

    // Flush beats out_ready in DONE
    wait_idle();
    a = 8'h21; b = 8'h42; sub = 1'b0; key = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("done_reached", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done", {in_ready, out_valid, result}, {2'b10, 8'h63});

    // Randomised operations with random backpressure
    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Wrong key locks the block in the decoy ring
    last = {cout, ovf, result};
    wait_idle();
    a = 8'h12; b = 8'h34; sub = 1'b0; key = 8'h00; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      key       = 8'hA5;
      in_valid  = 1'($urandom);
      flush     = 1'($urandom);
      out_ready = 1'($urandom);
      check("decoy_ready", in_ready, 0);
      check("decoy_valid", out_valid, 0);
      tick();
    end
    check("decoy_datapath", {cout, ovf, result}, last);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("unlock_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    run_op(8'h33, 8'h44, 1'b0, 1);

    // Asynchronous reset mid-RUN
    wait_idle();
    a = 8'hC3; b = 8'h5A; sub = 1'b1; key = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrun_rst", {in_ready, out_valid, cout, ovf, result}, {2'b10, 10'h0});
    tick();
    rst = 1'b0;
    tick();
    run_op(8'h01, 8'h02, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_sub_serial_p.md
Name: add_sub_serial_p

Overview:
- Parametrised successor to the team's serial adder: a digit-serial add/subtract unit with configurable operand width and bits-per-cycle.
- Uses valid/ready handshakes on input and output, and reports carry-out and signed overflow.
- Keeps control obfuscation: operands are XOR-masked while stored, and a key check steers the FSM into a lock-up ring of decoy states on mismatch.
- Sits as a leaf arithmetic engine behind a host register interface in the obfuscation test designs.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per RUN cycle; legal values 1, 2, 4, 8.
- A_MASK, WIDTH'h0, constant XOR mask applied to operand a while stored.
- B_MASK, WIDTH'h0, constant XOR mask applied to operand b while stored.
- KEY_W, 8, key width.
- KEY, 8'hA5, unlock key value.
- N_DECOY, 4, number of decoy states; range 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand a
- b  in  WIDTH  operand b
- sub  in  1  0 selects a+b; 1 selects a-b
- key  in  KEY_W  unlock key, sampled on input handshake
- flush  in  1  abort current operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference
- cout  out  1  carry out; for sub, 1 = no borrow
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset:
  - state=IDLE; result, cout, ovf, the count register and all operand/carry registers are 0.
  - Reset has priority in every state, including decoys and mid-RUN.
- Derived constants:
  - NDIG = WIDTH/DIGIT.
  - The count register is clog2(NDIG) bits wide, minimum 1.
- States: IDLE, RUN, DONE, DECOY_0..DECOY_{N_DECOY-1}.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are Moore outputs.
- IDLE:
  - On in_valid with key==KEY:
    - Load a_reg=a^A_MASK and b_reg=b^B_MASK.
    - Latch sub; carry=sub; count=0; result=0; go to RUN.
  - On in_valid with key!=KEY: go to DECOY_0; no register changes.
- RUN, each cycle:
  - da = a_reg[DIGIT-1:0] ^ A_MASK[count*DIGIT +: DIGIT].
  - db = (b_reg[DIGIT-1:0] ^ B_MASK[count*DIGIT +: DIGIT]) ^ {DIGIT{sub}}.
  - {c,s} = da + db + carry.
  - result <= {s, result[WIDTH-1:DIGIT]}.
  - a_reg and b_reg shift right by DIGIT; carry<=c; count<=count+1.
  - When count==NDIG-1:
    - cout<=c.
    - ovf <= c XOR (carry into bit DIGIT-1 of the final digit).
    - Go to DONE.
  - Latency: NDIG RUN cycles; out_valid rises on the cycle after the last RUN cycle, NDIG+1 cycles after the input handshake.
- DONE:
  - result, cout and ovf are held stable while out_ready is low.
  - On out_ready, go to IDLE. Outputs keep their values until the next accept.
- flush:
  - In RUN or DONE, go to IDLE next cycle; out_valid drops.
  - result, cout, ovf keep their current values.
  - flush beats out_ready when both are high in DONE.
  - flush is ignored in IDLE and in the decoy states.
- Decoy ring:
  - DECOY_i goes to DECOY_{(i+1) mod N_DECOY} every cycle.
  - in_ready=0, out_valid=0; no datapath register changes.
  - The only exit is reset.
- State encoding: one-hot is forbidden. Decoy states are encoded interleaved with the real states so the encoding does not reveal which states are decoys.
- Full-width wrap: result is taken modulo 2^WIDTH; the carry is reported only through cout.

Decomposition:
- Package add_sub_serial_pkg holds:
  - the state enum, covering real states and the maximum of 8 decoys;
  - the encoding constants;
  - a clog2-based count-width function.
- Sub-module add_sub_digit: combinational DIGIT-bit ripple adder.
  - Inputs: da, db, cin.
  - Outputs: s, cout, c_msb_in (carry into the MSB, used for ovf).
- The FSM and the shift registers stay in the top module.

Test Plan (WIDTH=8, DIGIT=2, masks 8'h3C/8'hC5, KEY=8'hA5, N_DECOY=4):
- Add with overflow: a=0x7F, b=0x01, sub=0, key=0xA5 -> out_valid high exactly 5 cycles after the handshake; result=0x80, cout=0, ovf=1.
- Subtract with borrow: a=0x05, b=0x07, sub=1 -> result=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
- Wrong key: handshake with key=0x00 -> in_ready stays 0 and out_valid stays 0 for 100 cycles while the state cycles through the 4 decoys; after a rst pulse, in_ready=1.
- Backpressure: add 0xFF+0x01 with out_ready=0 for 10 cycles -> result=0x00, cout=1, ovf=0 held stable throughout; out_ready=1 -> IDLE next cycle.
- Flush and reset mid-operation:
  - flush on the 2nd RUN cycle -> IDLE next cycle, out_valid never asserted; the next operation 0x10+0x20 gives 0x30.
  - rst asserted mid-RUN -> all outputs 0 immediately.
